// File: rtl/scfifo_mw.sv
// Single-clock FIFO with independent write/read widths, packing or unpacking in units of the
// narrower width. Define SCFIFO_MW_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module scfifo_mw #(
   parameter int    lpm_width          = 8,
   parameter int    lpm_width_r        = 32,
   parameter int    lpm_numwords       = 8,
   parameter int    lpm_widthu         = 4,
   parameter int    lpm_widthu_r       = 2,
   parameter string lpm_showahead      = "OFF",
   parameter string overflow_checking  = "ON",
   parameter string underflow_checking = "ON",
   parameter int    almost_full_value  = 0,
   parameter int    almost_empty_value = 0
) (
   input  logic                    clock,
   input  logic                    aclr,
   input  logic                    sclr,
   input  logic [lpm_width-1:0]    data,
   input  logic                    wrreq,
   input  logic                    rdreq,
   output logic [lpm_width_r-1:0]  q,
   output logic                    empty,
   output logic                    full,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [lpm_widthu-1:0]   usedw,
   output logic [lpm_widthu_r-1:0] rdusedw
`ifdef SCFIFO_MW_ERR_FLAGS_EN
   ,
   output logic                    overflow,
   output logic                    underflow
`endif
);

   localparam int Unit = (lpm_width < lpm_width_r) ? lpm_width : lpm_width_r;
   localparam int Kw   = lpm_width / Unit;
   localparam int Kr   = lpm_width_r / Unit;
   localparam int Nu   = lpm_numwords * Kw;
   localparam int CntW = $clog2(Nu + 1);
   localparam int PtrW = (Nu > 1) ? $clog2(Nu) : 1;
   localparam int KwSh = $clog2(Kw);
   localparam int KrSh = $clog2(Kr);
   localparam bit ShowAhead = (lpm_showahead == "ON");
   localparam bit OvfCheck  = (overflow_checking == "ON");
   localparam bit UdfCheck  = (underflow_checking == "ON");

   logic [Unit-1:0]        mem_q [Nu];
   logic [Unit-1:0]        mem_d [Nu];
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [lpm_width_r-1:0] q_q, q_d, head;
   logic                   wr_ena, rd_ena;

   function automatic logic [PtrW-1:0] ptr_adv(input logic [PtrW-1:0] ptr, input int k);
      int t;
      t = int'(ptr) + k;
      if (t >= Nu) t = t - Nu;
      return PtrW'(t);
   endfunction

   assign empty   = (int'(cnt_q) < Kr);
   assign full    = (int'(cnt_q) > Nu - Kw);
   assign wr_ena  = wrreq & (~full | ~OvfCheck);
   assign rd_ena  = rdreq & (~empty | ~UdfCheck);
   assign usedw   = lpm_widthu'(cnt_q >> KwSh);
   assign rdusedw = lpm_widthu_r'(cnt_q >> KrSh);
   assign almost_full  = (int'(usedw) >= almost_full_value);
   assign almost_empty = (int'(rdusedw) < almost_empty_value);

   // Read words never straddle the wrap point, since Nu is a multiple of Kr.
   always_comb begin
      head = '0;
      for (int i = 0; i < Kr; i++) begin
         head[i*Unit +: Unit] = mem_q[rd_ptr_q + PtrW'(i)];
      end
   end

   assign q = ShowAhead ? (empty ? '0 : head) : q_q;

   always_comb begin
      int t;
      mem_d    = mem_q;
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      q_d      = q_q;
      t        = int'(cnt_q);
      if (sclr) begin
         cnt_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         q_d      = '0;
      end else begin
         if (wr_ena) begin
            for (int i = 0; i < Kw; i++) begin
               mem_d[wr_ptr_q + PtrW'(i)] = data[i*Unit +: Unit];
            end
            wr_ptr_d = ptr_adv(wr_ptr_q, Kw);
            t        = t + Kw;
         end
         if (rd_ena) begin
            q_d      = head;
            rd_ptr_d = ptr_adv(rd_ptr_q, Kr);
            t        = t - Kr;
         end
         if (t < 0) t = 0;
         if (t > Nu) t = Nu;
         cnt_d = CntW'(t);
      end
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         q_q      <= '0;
      end else begin
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         q_q      <= q_d;
      end
   end

   // Storage is not reset; validity is tracked by cnt and the pointers alone.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

`ifdef SCFIFO_MW_ERR_FLAGS_EN
   logic overflow_q, overflow_d, underflow_q, underflow_d;

   always_comb begin
      overflow_d  = overflow_q | (wrreq & full);
      underflow_d = underflow_q | (rdreq & empty);
      if (sclr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule

// File: doc/scfifo_mw.md
Name: scfifo_mw

Overview:
- Single-clock show-ahead/normal FIFO with independent write and read port widths. Both directions are supported: narrow-to-wide packing and wide-to-narrow unpacking.
- Successor to the existing single-width scfifo clone. Used at width-conversion points in datapaths, such as byte streams to 32-bit bus words.
- Storage is organised in units of the narrower width. Occupancy is reported in both write-word and read-word terms.

Parameters:
- lpm_width, 8, write data width W.
- lpm_width_r, 32, read data width WR. The ratio max(W,WR)/min(W,WR) is 1, 2, 4 or 8.
- lpm_numwords, 8, capacity in write words. lpm_numwords*W is a multiple of WR.
- lpm_widthu, 4, write-side usedw width: clog2(lpm_numwords+1).
- lpm_widthu_r, 2, read-side rdusedw width: clog2(lpm_numwords*W/WR+1).
- lpm_showahead, "OFF", "ON" presents the head read word on q without rdreq.
- overflow_checking, "ON", "ON" drops writes while full.
- underflow_checking, "ON", "ON" drops reads while empty.
- almost_full_value, 0, almost_full threshold in write words.
- almost_empty_value, 0, almost_empty threshold in read words.

Ports:
- clock  in  1  clock, rising edge.
- aclr  in  1  asynchronous reset, active-high.
- sclr  in  1  synchronous clear, active-high.
- data  in  W  write data.
- wrreq  in  1  write request.
- rdreq  in  1  read request (acknowledge in show-ahead mode).
- q  out  WR  read data.
- empty  out  1  fewer than one complete read word stored.
- full  out  1  no room for one more write word.
- almost_full  out  1  usedw >= almost_full_value.
- almost_empty  out  1  rdusedw < almost_empty_value.
- usedw  out  lpm_widthu  stored units / (W/U), floored.
- rdusedw  out  lpm_widthu_r  stored units / (WR/U), floored.

Behaviour:
- Definitions: U = min(W,WR); KW = W/U; KR = WR/U; capacity NU = lpm_numwords*KW units.
- Internal unit counter cnt ranges 0..NU. Read and write unit pointers wrap modulo NU.
- Decided: reset aclr, asynchronous, active-high; clock clock.
- aclr, and sclr at a clock edge, force:
  - cnt = 0 and both pointers = 0;
  - q = 0, empty = 1, full = 0, usedw = 0, rdusedw = 0;
  - almost_full = (almost_full_value == 0); almost_empty = (almost_empty_value > 0).
- sclr has priority over wrreq/rdreq in the same cycle.
- Flags are combinational decodes of the registered cnt:
  - empty = (cnt < KR);
  - full = (cnt > NU - KW).
- Write acceptance: wr_ena = wrreq & (full==0, or overflow_checking "OFF"). An accepted write stores KW units starting at the write pointer.
- Read acceptance: rd_ena = rdreq & (empty==0, or underflow_checking "OFF"). An accepted read consumes KR units starting at the read pointer.
- Update on the same edge: cnt += KW*wr_ena - KR*rd_ena.
- A simultaneous write and read is evaluated on pre-edge flags. A write while full is dropped even if a read is also accepted.
- Ordering is little-endian:
  - narrow-to-wide: the first written word lands in q[U-1:0];
  - wide-to-narrow: data[U-1:0] is read first.
- A write whose units complete a read word makes empty fall on the next cycle, not earlier.
- Normal mode: q updates one cycle after an accepted read and holds otherwise.
- Show-ahead mode: q reflects the head read word while empty==0 and advances on the edge of an accepted read. q is undefined while empty==1.
- Unchecked overflow/underflow corrupts contents only. cnt saturates at 0 and NU.
- aclr asserted mid-transfer discards any partially packed word.

Optional Feature:
- Macro SCFIFO_MW_ERR_FLAGS_EN adds two outputs, overflow and underflow, each 1 bit.
  - overflow sets sticky when wrreq is asserted while full==1.
  - underflow sets sticky when rdreq is asserted while empty==1.
  - Both clear only on aclr or sclr. They are independent of the checking parameters.
- Without the macro, these ports and their logic do not exist.

Test Plan:
- W=8, WR=32, numwords=8: write 0x11, 0x22, 0x33 -> empty=1, usedw=3, rdusedw=0. Write 0x44 -> next cycle empty=0, rdusedw=1. Pulse rdreq -> q=0x44332211 one cycle later, usedw=0.
- Same config: 8 writes -> full=1, usedw=8, rdusedw=2. A 9th write is dropped. With SCFIFO_MW_ERR_FLAGS_EN, overflow=1 and stays 1 until sclr.
- W=32, WR=8, numwords=4, show-ahead ON: write 0xA1B2C3D4 -> rdusedw=4, q=0xD4. Three accepted reads -> q=0xC3, 0xB2, 0xA1. A fourth read -> empty=1.
- W=8, WR=16, numwords=4 holding 3 bytes: simultaneous wrreq and rdreq -> cnt 3->2, usedw=2, rdusedw=1, q=first 16-bit pair.
- Any state with cnt>0: assert aclr mid-cycle -> immediately empty=1, full=0, usedw=0, q=0. The next write/read sequence restarts at pointer 0 with correct ordering.
- almost_full_value=6, almost_empty_value=2, W=WR=8, numwords=8: 6 writes -> almost_full=1. Reads to usedw=1 -> almost_empty=1.
